// File: rtl/gf2m_digit_mult_if.sv
// Operand/result bundle for the GF(2^M) field multiplier.
// The point-arithmetic controller is the master; the multiplier is the slave.
interface gf2m_digit_mult_if #(
   parameter int M = 163
);
   logic         start;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         busy;
   logic         done;
   logic [M-1:0] c;

   modport master (output start, a, b, input busy, done, c);
   modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier: consumes D bits of b per
// clock, MSB-first, with in-loop reduction by f(x) = x^M + POLY.
module gf2m_digit_mult #(
   parameter int           M    = 163,
   parameter int           D    = 2,
   parameter logic [M-1:0] POLY = 163'hC9
) (
   input logic              clk,
   input logic              rst_n,
   gf2m_digit_mult_if.slave bus
);
   localparam int N  = (M + D - 1) / D;
   localparam int NB = N * D;
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [M-1:0]    a_r;
   logic [NB-1:0]   b_r;
   logic [M-1:0]    acc;
   logic [CW-1:0]   cnt;
   logic [M-1:0]    c_r;
   logic            busy_r;
   logic            done_r;

   logic [D-1:0]    digit;
   logic [M+D-1:0]  prod;
   logic [M-1:0]    acc_next;

   // Folds the D bits above x^(M-1) back in via x^M = POLY. POLY's top bit is
   // below M-D, so a single pass always lands inside M bits.
   function automatic logic [M-1:0] fold(input logic [M+D-1:0] v);
      logic [M-1:0] r;
      r = v[M-1:0];
      for (int i = 0; i < D; i++)
         if (v[M+i]) r = r ^ (POLY << i);
      return r;
   endfunction

   always_comb begin
      digit = b_r[NB-1 -: D];
      prod  = '0;
      for (int i = 0; i < D; i++)
         if (digit[i]) prod = prod ^ ({{D{1'b0}}, a_r} << i);
      acc_next = fold({acc, {D{1'b0}}}) ^ fold(prod);
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would chain acc/b_r updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         cnt    <= '0;
         c_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r    <= bus.a;
                  b_r    <= NB'(bus.b);
                  acc    <= '0;
                  cnt    <= CW'(N - 1);
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               b_r <= b_r << D;
               if (cnt == '0) begin
                  c_r    <= acc_next;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.c    = c_r;
endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Self-checking bench for gf2m_digit_mult: directed corner cases plus random
// operands against a bit-serial shift-and-reduce reference model.
module tb_gf2m_digit_mult;
   localparam int           M    = 163;
   localparam logic [M-1:0] POLY = 163'hC9;
   localparam int           N2   = 82;
   localparam int           N1   = 163;
   localparam int           N3   = 55;
   localparam int           N4   = 41;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gf2m_digit_mult_if #(.M(M)) bus ();
   gf2m_digit_mult_if #(.M(M)) if_d1 ();
   gf2m_digit_mult_if #(.M(M)) if_d3 ();
   gf2m_digit_mult_if #(.M(M)) if_d4 ();

   logic         sw_start;
   logic [M-1:0] sw_a, sw_b;
   assign if_d1.start = sw_start;
   assign if_d1.a     = sw_a;
   assign if_d1.b     = sw_b;
   assign if_d3.start = sw_start;
   assign if_d3.a     = sw_a;
   assign if_d3.b     = sw_b;
   assign if_d4.start = sw_start;
   assign if_d4.a     = sw_a;
   assign if_d4.b     = sw_b;

   gf2m_digit_mult #(.M(M), .D(2), .POLY(POLY)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   gf2m_digit_mult #(.M(M), .D(1), .POLY(POLY)) u_d1  (.clk(clk), .rst_n(rst_n), .bus(if_d1));
   gf2m_digit_mult #(.M(M), .D(3), .POLY(POLY)) u_d3  (.clk(clk), .rst_n(rst_n), .bus(if_d3));
   gf2m_digit_mult #(.M(M), .D(4), .POLY(POLY)) u_d4  (.clk(clk), .rst_n(rst_n), .bus(if_d4));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Horner over single bits of b: r = r*x mod f, then add a if the bit is set.
   function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M-1:0] r;
      logic         msb;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         msb = r[M-1];
         r   = r << 1;
         if (msb) r = r ^ POLY;
         if (y[i]) r = r ^ x;
      end
      return r;
   endfunction

   function automatic logic [M-1:0] rand_fe();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[M-1:0];
   endfunction

   task automatic run_op(input logic [M-1:0] ta, input logic [M-1:0] tb_v,
                         output logic [M-1:0] tc, output int k);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 400) begin
         @(negedge clk);
         k++;
      end
      tc = bus.c;
   endtask

   initial begin
      logic [M-1:0] ra, rb, rc, rc2, a2, b2, c1, c3, c4;
      logic [M-1:0] one;
      int           k, j, busy_cycles, k1, k3, k4;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      sw_start  = 1'b0;
      sw_a      = '0;
      sw_b      = '0;
      one       = M'(1);

      repeat (3) @(negedge clk);
      check("reset_busy", M'(bus.busy), '0);
      check("reset_done", M'(bus.done), '0);
      check("reset_c", bus.c, '0);
      rst_n = 1'b1;

      // Identity: busy for N cycles, a single done pulse, c = 1.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = one;
      bus.b     = one;
      @(negedge clk);
      bus.start = 1'b0;
      check("id_busy_first", M'(bus.busy), M'(1));
      k = 0;
      busy_cycles = 0;
      while (!bus.done && k < 400) begin
         if (bus.busy) busy_cycles++;
         @(negedge clk);
         k++;
      end
      check("id_latency", M'(k), M'(N2));
      check("id_busy_cycles", M'(busy_cycles), M'(N2));
      check("id_busy_at_done", M'(bus.busy), '0);
      check("id_c", bus.c, one);
      @(negedge clk);
      check("id_done_pulse", M'(bus.done), '0);
      check("id_c_held", bus.c, one);

      // Reduction corners: x^163 and x^164.
      ra = '0;
      ra[M-1] = 1'b1;
      run_op(ra, M'(2), rc, k);
      check("red_x163", rc, M'('hC9));
      run_op(ra, M'(4), rc, k);
      check("red_x164", rc, M'('h192));

      rb = rand_fe();
      run_op('0, rb, rc, k);
      check("zero_a", rc, '0);

      // Random pairs, both operand orders.
      for (int i = 0; i < 200; i++) begin
         ra = rand_fe();
         rb = rand_fe();
         run_op(ra, rb, rc, k);
         check("rand_ab", rc, ref_mul(ra, rb));
         check("rand_lat", M'(k), M'(N2));
         run_op(rb, ra, rc2, k);
         check("rand_ba", rc2, ref_mul(ra, rb));
      end

      // Start while busy is ignored; start in the done cycle is accepted.
      ra = rand_fe();
      rb = rand_fe();
      a2 = rand_fe();
      b2 = rand_fe();
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ra;
      bus.b     = rb;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 400) begin
         @(negedge clk);
         k++;
         if (k == 10) begin
            bus.start = 1'b1;
            bus.a     = rand_fe();
            bus.b     = rand_fe();
         end else if (k == 11) begin
            bus.start = 1'b0;
         end
      end
      check("b2b_first_lat", M'(k), M'(N2));
      check("b2b_first_c", bus.c, ref_mul(ra, rb));
      bus.start = 1'b1;
      bus.a     = a2;
      bus.b     = b2;
      @(negedge clk);
      bus.start = 1'b0;
      j = 1;
      check("b2b_c_stable", bus.c, ref_mul(ra, rb));
      while (!bus.done && j < 400) begin
         @(negedge clk);
         j++;
      end
      check("b2b_spacing", M'(j), M'(N2 + 1));
      check("b2b_second_c", bus.c, ref_mul(a2, b2));

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = rand_fe();
      bus.b     = rand_fe();
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 40; i++) @(negedge clk);
      check("rst_pre_busy", M'(bus.busy), M'(1));
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", M'(bus.busy), '0);
      check("rst_done", M'(bus.done), '0);
      check("rst_c", bus.c, '0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(M'(3), M'(3), rc, k);
      check("rst_after_c", rc, M'(5));
      check("rst_after_lat", M'(k), M'(N2));

      // Digit-size sweep on the same operands.
      for (int i = 0; i < 20; i++) begin
         ra = rand_fe();
         rb = rand_fe();
         @(negedge clk);
         sw_start = 1'b1;
         sw_a     = ra;
         sw_b     = rb;
         @(negedge clk);
         sw_start = 1'b0;
         k  = 0;
         k1 = -1;
         k3 = -1;
         k4 = -1;
         c1 = '0;
         c3 = '0;
         c4 = '0;
         while ((k1 < 0 || k3 < 0 || k4 < 0) && k < 400) begin
            @(negedge clk);
            k++;
            if (if_d1.done && k1 < 0) begin k1 = k; c1 = if_d1.c; end
            if (if_d3.done && k3 < 0) begin k3 = k; c3 = if_d3.c; end
            if (if_d4.done && k4 < 0) begin k4 = k; c4 = if_d4.c; end
         end
         check("d1_c", c1, ref_mul(ra, rb));
         check("d3_c", c3, ref_mul(ra, rb));
         check("d4_c", c4, ref_mul(ra, rb));
         check("d1_lat", M'(k1), M'(N1));
         check("d3_lat", M'(k3), M'(N3));
         check("d4_lat", M'(k4), M'(N4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
